bsg_counter_burst_seq: RTL and testbench
========================================

Name: bsg_counter_burst_seq

Overview:
Burst sequencer that sits directly upstream of a settable/enabled up-counter (set/en/val style, width_p bits, wraps modulo 2^width_p).
- Accepts a burst request (start index, beat count) over a valid/ready handshake.
- Drives the counter's set, enable and load-value inputs.
- Watches the counter's count output and presents each index as a beat to a downstream consumer, with stall support.
- Flags the last beat and pulses done when the burst completes.

Parameters:
width_p, 3, counter width; also the width of start index and length fields.

Ports:
clk_i  in  1  clock, all state updates on rising edge
reset_n_i  in  1  asynchronous active-low reset
v_i  in  1  burst request valid
ready_o  out  1  sequencer can accept a request
start_i  in  width_p  first index of the burst
len_m1_i  in  width_p  beats minus one (0 means 1 beat, 2^width_p-1 means 2^width_p beats)
set_o  out  1  to counter set input
en_o  out  1  to counter enable input
val_o  out  width_p  to counter load value
count_i  in  width_p  counter's current count
stall_i  in  1  downstream cannot take the current beat
beat_v_o  out  1  count_i is a live beat index this cycle
last_o  out  1  current beat is the final beat of the burst
done_o  out  1  one-cycle pulse after the final beat is taken

Behaviour:
- State machine states: IDLE, LOAD, RUN, DONE.
- Reset:
  - reset_n_i low forces state=IDLE immediately, asynchronously; start/remaining registers clear to 0.
  - Resulting outputs: ready_o=1, set_o=0, en_o=0, val_o=0, beat_v_o=0, last_o=0, done_o=0.
  - Reset mid-burst abandons the burst with no done_o.
  - The counter's own reset is independent; the sequencer always issues set before the first beat, so the counter value at burst start is irrelevant.
- IDLE:
  - ready_o=1.
  - v_i&ready_o at a clock edge captures start_i into start_r and len_m1_i into rem_r, then goes to LOAD.
  - v_i while not IDLE is ignored; the requester holds it.
- LOAD (exactly 1 cycle):
  - set_o=1, val_o=start_r, en_o=0, ready_o=0.
  - The counter loads start_r at the edge; go to RUN.
- RUN:
  - beat_v_o=1, last_o=(rem_r==0), ready_o=0.
  - stall_i=1: en_o=0, nothing changes, and the beat is held (count_i stable).
  - stall_i=0 and rem_r!=0: en_o=1 and rem_r decrements; the counter advances next edge.
  - stall_i=0 and rem_r==0: en_o=0 (the counter rests on the final index) and the state goes to DONE.
- DONE (exactly 1 cycle):
  - done_o=1, ready_o=0, all else 0; go to IDLE.
- Output timing:
  - set_o, val_o, beat_v_o, last_o, done_o and ready_o are decoded from state and registers only.
  - en_o additionally depends combinationally on stall_i.
  - val_o=0 outside LOAD.
- Latency and throughput:
  - First beat is visible 2 cycles after the accept edge.
  - An unstalled N-beat burst occupies N+2 cycles after the accept edge; the next request is accepted N+3 edges after the previous one.
- Arithmetic and width:
  - Indices wrap modulo 2^width_p, handled by the counter; the sequencer never compares count_i with an end value, it counts beats via rem_r.
  - rem_r is width_p bits and only decrements when nonzero, so it never underflows.
- Boundary conditions:
  - len_m1_i=0 gives a single beat with last_o=1 on the first RUN cycle.
  - len_m1_i=all-ones gives 2^width_p beats and visits every index exactly once.
  - A stall on the last beat holds last_o=1 and beat_v_o=1 until released.

Test Plan:
1. Reset: assert reset_n_i low mid-cycle -> outputs go to reset values immediately, ready_o=1; deassert, then request start=2, len_m1=2 -> beats 2,3,4 on consecutive cycles, last_o only on 4, done_o one cycle later.
2. Wrap: start=6, len_m1=3, no stall -> beats 6,7,0,1; en_o=1 on the first three beat cycles only; count_i stays 1 after the burst.
3. Single beat and full burst: len_m1=0, start=5 -> one beat at 5 with last_o=1. Then start=0, len_m1=7 -> beats 0..7 each exactly once.
4. Stall: start=1, len_m1=2 with stall_i=1 for 2 cycles on beat 2 and for 1 cycle on the last beat -> beats 1,2,2,2,3,3, with en_o=0 on every stalled cycle and done_o after the final unstalled cycle.
5. Handshake: hold v_i=1 continuously with changing start_i -> only the values present at ready_o=1 edges are used; bursts are back-to-back with accepts N+3 edges apart.
6. Reset mid-RUN (start=3, len_m1=5, reset after 2 beats) -> IDLE immediately, no done_o pulse; the next burst start=0, len_m1=1 gives beats 0,1 correctly.

Source files
------------

// File: rtl/bsg_counter_burst_seq_if.sv
// bsg_counter_burst_seq_if: request, counter-control and beat signals between the sequencer and its neighbours
interface bsg_counter_burst_seq_if #(parameter int width_p = 3) ();
  logic               v;
  logic               ready;
  logic [width_p-1:0] start;
  logic [width_p-1:0] len_m1;
  logic               set;
  logic               en;
  logic [width_p-1:0] val;
  logic [width_p-1:0] count;
  logic               stall;
  logic               beat_v;
  logic               last;
  logic               done;
  modport slave (
    input  v, start, len_m1, count, stall,
    output ready, set, en, val, beat_v, last, done
  );
  modport master (
    output v, start, len_m1, count, stall,
    input  ready, set, en, val, beat_v, last, done
  );
endinterface

// File: rtl/bsg_counter_burst_seq.sv
// bsg_counter_burst_seq: burst sequencer that loads and steps an external up-counter, presenting each count as a beat
module bsg_counter_burst_seq #(
  parameter int width_p = 3
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  bsg_counter_burst_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  state_e             state_r, state_n;
  logic [width_p-1:0] start_r, rem_r;
  logic               rem_zero;
  assign rem_zero = (rem_r == '0);
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      start_r <= '0;
      rem_r   <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == IDLE && bus.v) begin
        start_r <= bus.start;
        rem_r   <= bus.len_m1;
      end else if (state_r == RUN && !bus.stall && !rem_zero) begin
        rem_r   <= rem_r - 1'b1;
      end
    end
  end
  // beats are counted via rem_r, never by comparing count against an end index
  always_comb begin
    state_n = state_r == IDLE ? (bus.v ? LOAD : IDLE)
            : state_r == LOAD ? RUN
            : state_r == RUN  ? ((!bus.stall && rem_zero) ? DONE : RUN)
            : IDLE;
  end
  assign bus.ready  = (state_r == IDLE);
  assign bus.set    = (state_r == LOAD);
  assign bus.val    = (state_r == LOAD) ? start_r : '0;
  assign bus.beat_v = (state_r == RUN);
  assign bus.last   = (state_r == RUN) && rem_zero;
  assign bus.en     = (state_r == RUN) && !bus.stall && !rem_zero;
  assign bus.done   = (state_r == DONE);
endmodule

// File: tb/tb_bsg_counter_burst_seq.sv
// tb_bsg_counter_burst_seq: directed bench with a behavioural set/en/val counter closing the loop
module tb_bsg_counter_burst_seq;
  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic [2:0] cnt = 3'd0;
  int         checks = 0;
  int         errors = 0;
  int         step = 0;
  bsg_counter_burst_seq_if #(.width_p(3)) bus ();
  bsg_counter_burst_seq #(.width_p(3)) dut (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  always_ff @(posedge clk_i) cnt <= bus.set ? bus.val : bus.en ? cnt + 3'd1 : cnt;
  assign bus.count = cnt;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL step%0d %s observed=%0h expected=%0h", step, tag, o, e);
    end
  endtask
  task automatic outs(input logic r, s, e, input logic [2:0] vl, input logic b, l, d);
    chk("ready", 32'(bus.ready), 32'(r));
    chk("set", 32'(bus.set), 32'(s));
    chk("en", 32'(bus.en), 32'(e));
    chk("val", 32'(bus.val), 32'(vl));
    chk("beat_v", 32'(bus.beat_v), 32'(b));
    chk("last", 32'(bus.last), 32'(l));
    chk("done", 32'(bus.done), 32'(d));
  endtask
  task automatic cyc(input logic v, input logic [2:0] st, ln, input logic sl,
                     input logic r, s, e, input logic [2:0] vl, input logic b, l, d, input logic [2:0] c);
    @(posedge clk_i);
    #1;
    bus.v = v; bus.start = st; bus.len_m1 = ln; bus.stall = sl;
    #1;
    step++;
    outs(r, s, e, vl, b, l, d);
    if (b) chk("count", 32'(cnt), 32'(c));
  endtask
  initial begin
    bus.v = 1'b0; bus.start = '0; bus.len_m1 = '0; bus.stall = 1'b0;
    #12;
    outs(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i) reset_n_i = 1'b1;
    // 1: start=2 len_m1=2
    cyc(1, 2, 2, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 1, 0, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 2);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 3);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 4);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    // 2: wrap start=6 len_m1=3
    cyc(1, 6, 3, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 1, 0, 6, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 6);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 7);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    // 3: single beat at 5, then full burst from 0
    cyc(1, 5, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    chk("count_rest", 32'(cnt), 32'd1);
    cyc(0, 0, 0, 0,  0, 1, 0, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 5);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 7, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 3'(i));
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 7);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    // 4: stalls, beats 1,2,2,2,3,3
    cyc(1, 1, 2, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 2);
    cyc(0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 2);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 2);
    cyc(0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0, 3);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 3);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    // 5: v held high, start changing; accepts 5 edges apart
    cyc(1, 4, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 3, 0,  0, 1, 0, 4, 0, 0, 0, 0);
    cyc(1, 3, 3, 0,  0, 0, 1, 0, 1, 0, 0, 4);
    cyc(1, 6, 3, 0,  0, 0, 0, 0, 1, 1, 0, 5);
    cyc(1, 1, 3, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 2, 4, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 5, 4, 0,  0, 0, 0, 0, 1, 1, 0, 0);
    cyc(1, 7, 4, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 7, 4, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    // 6: reset mid-RUN, then start=0 len_m1=1
    cyc(1, 3, 5, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 1, 0, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 3);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 4);
    #2 reset_n_i = 1'b0;
    #1 outs(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    @(negedge clk_i) reset_n_i = 1'b1;
    cyc(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
